// File: rtl/seg7_scan4.sv
// seg7_scan4: four-digit multiplexed scan controller for a common-anode
// 7-segment display. Feeds the hex decoder nibble, drives the anodes and the
// decimal point, keeps a tear-free shadow of the displayed value (commits only
// at frame boundaries), inserts an all-off gap before each digit and can blank
// leading zeros.
module seg7_scan4 #(
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYC     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  x,
  output logic [3:0]  an,
  output logic        dp,
  output logic        load_ack
);

  localparam logic [0:0] ST_GAP = 1'b0;
  localparam logic [0:0] ST_ON  = 1'b1;

  localparam int CNT_MAX = (REFRESH_DIV > GAP_CYC) ? REFRESH_DIV : GAP_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] ON_LAST  = CW'(REFRESH_DIV - 1);

  // scan state
  logic [0:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    idx, idx_n;
  logic          boundary;

  // displayed (shadow) and pending copies
  logic [15:0]   shadow, shadow_n;
  logic [3:0]    shadow_dp, shadow_dp_n;
  logic [15:0]   pend_value, pend_value_n;
  logic [3:0]    pend_dp, pend_dp_n;
  logic          pending, pending_n;
  logic          ack_n;

  // next registered outputs
  logic          lz_blank;
  logic          lit;
  logic [3:0]    x_n;
  logic [3:0]    an_n;
  logic          dp_n;

  // Scan sequencer: GAP -> ON per digit, frozen while en is low.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    boundary = 1'b0;
    if (en) begin
      if (state == ST_GAP) begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          state_n = ST_ON;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end else begin
        if (cnt == ON_LAST) begin
          cnt_n    = '0;
          idx_n    = idx + 2'd1;
          state_n  = ST_GAP;
          boundary = (idx == 2'd3);
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
    end
  end

  // Load path: a load on the boundary bypasses pending and commits directly;
  // otherwise loads collect in pending (last write wins) until the boundary.
  always_comb begin
    shadow_n     = shadow;
    shadow_dp_n  = shadow_dp;
    pend_value_n = pend_value;
    pend_dp_n    = pend_dp;
    pending_n    = pending;
    ack_n        = 1'b0;
    if (boundary) begin
      if (load) begin
        shadow_n    = value;
        shadow_dp_n = dp_in;
        pending_n   = 1'b0;
        ack_n       = 1'b1;
      end else if (pending) begin
        shadow_n    = pend_value;
        shadow_dp_n = pend_dp;
        pending_n   = 1'b0;
        ack_n       = 1'b1;
      end
    end else if (load) begin
      pend_value_n = value;
      pend_dp_n    = dp_in;
      pending_n    = 1'b1;
    end
  end

  // Output decode from the next-cycle state so the registered outputs line up
  // with the state register they describe.
  always_comb begin
    lz_blank = blank_lz && (idx_n != 2'd0) &&
               ((shadow_n >> {idx_n, 2'b00}) == 16'h0000);
    lit      = en && (state_n == ST_ON) && !lz_blank;
    x_n      = shadow_n[{idx_n, 2'b00} +: 4];
    an_n     = 4'b1111;
    dp_n     = 1'b1;
    if (lit) begin
      an_n[idx_n] = 1'b0;
      dp_n        = ~shadow_dp_n[idx_n];
    end
  end

  // State, shadow and pending registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_GAP;
      cnt        <= '0;
      idx        <= '0;
      shadow     <= '0;
      shadow_dp  <= '0;
      pend_value <= '0;
      pend_dp    <= '0;
      pending    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      shadow     <= shadow_n;
      shadow_dp  <= shadow_dp_n;
      pend_value <= pend_value_n;
      pend_dp    <= pend_dp_n;
      pending    <= pending_n;
    end
  end

  // Registered display outputs and commit acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x        <= '0;
      an       <= '1;
      dp       <= 1'b1;
      load_ack <= 1'b0;
    end else begin
      x        <= x_n;
      an       <= an_n;
      dp       <= dp_n;
      load_ack <= ack_n;
    end
  end

endmodule

// File: tb/tb_seg7_scan4.sv
// tb_seg7_scan4: scoreboard bench for seg7_scan4 with REFRESH_DIV=4, GAP_CYC=2.
// A frame-position model pushes the expected outputs at each rising edge; they
// are popped and compared on the following falling edge.
module tb_seg7_scan4;

  localparam int RD    = 4;
  localparam int GC    = 2;
  localparam int SLOT  = RD + GC;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n, en, load, blank_lz;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  x, an;
  logic        dp, load_ack;

  seg7_scan4 #(.REFRESH_DIV(RD), .GAP_CYC(GC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value),
    .dp_in(dp_in), .blank_lz(blank_lz), .x(x), .an(an), .dp(dp),
    .load_ack(load_ack)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model state
  int          m_pos;
  logic [15:0] m_sh, m_pv;
  logic [3:0]  m_sdp, m_pdp;
  logic        m_pend;
  logic [9:0]  exp_q[$];

  // monitors
  int   lit_cnt[4];
  int   gap_cnt, dp_low, ack_cnt;
  logic watch_abcd, abcd_seen;
  logic [15:0] abcd = 16'hABCD;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic clear_mon();
    for (int k = 0; k < 4; k++) lit_cnt[k] = 0;
    gap_cnt = 0; dp_low = 0; ack_cnt = 0; abcd_seen = 1'b0;
  endtask

  task automatic tick();
    logic [9:0] e;
    logic [9:0] got;
    logic       bnd, ack, lit;
    int         slot, ph;
    @(posedge clk);
    if (!rst_n) begin
      m_pos = 0; m_sh = '0; m_sdp = '0; m_pend = 1'b0;
      e = {1'b0, 4'hF, 1'b1, 4'h0};
    end else begin
      bnd = en && (m_pos == FRAME - 1);
      ack = 1'b0;
      if (en) m_pos = (m_pos + 1) % FRAME;
      if (bnd) begin
        if (load) begin
          m_sh = value; m_sdp = dp_in; m_pend = 1'b0; ack = 1'b1;
        end else if (m_pend) begin
          m_sh = m_pv; m_sdp = m_pdp; m_pend = 1'b0; ack = 1'b1;
        end
      end else if (load) begin
        m_pv = value; m_pdp = dp_in; m_pend = 1'b1;
      end
      slot = m_pos / SLOT;
      ph   = m_pos % SLOT;
      lit  = en && (ph >= GC) && !(blank_lz && slot != 0 && (m_sh >> (4 * slot)) == 16'h0);
      e = {ack, lit ? ~(4'b0001 << slot) : 4'hF, lit ? ~m_sdp[slot] : 1'b1, m_sh[slot*4 +: 4]};
    end
    exp_q.push_back(e);
    @(negedge clk);
    got = {load_ack, an, dp, x};
    check_val("scan", {22'd0, got}, {22'd0, exp_q.pop_front()});
    if (load_ack) ack_cnt++;
    if (!dp) dp_low++;
    if (an == 4'hF) gap_cnt++;
    for (int k = 0; k < 4; k++) begin
      if (an == ~(4'b0001 << k)) begin
        lit_cnt[k]++;
        if (watch_abcd && x == abcd[k*4 +: 4]) abcd_seen = 1'b1;
      end
    end
  endtask

  task automatic run_to(input int target);
    int n = 0;
    while (m_pos != target && n < 3 * FRAME) begin
      tick();
      n++;
    end
    if (m_pos != target) check_val("run_to_timeout", m_pos, target);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_lit(input string tag, input int e3, input int e2, input int e1, input int e0);
    check_val($sformatf("%s_lit3", tag), lit_cnt[3], e3);
    check_val($sformatf("%s_lit2", tag), lit_cnt[2], e2);
    check_val($sformatf("%s_lit1", tag), lit_cnt[1], e1);
    check_val($sformatf("%s_lit0", tag), lit_cnt[0], e0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0;
    watch_abcd = 1'b0;
    m_pos = 0; m_sh = '0; m_sdp = '0; m_pv = '0; m_pdp = '0; m_pend = 1'b0;
    clear_mon();
    run(2);
    check_val("rst_an", an, 4'hF);
    check_val("rst_dp", dp, 1);
    check_val("rst_x", x, 0);
    check_val("rst_ack", load_ack, 0);

    // 1: basic load, commits at first boundary
    rst_n = 1'b1; en = 1'b1;
    clear_mon();
    value = 16'h1234; load = 1'b1;
    tick();
    load = 1'b0;
    run_to(0);
    run(2 * FRAME);
    check_val("p1_acks", ack_cnt, 1);
    clear_mon();
    run(FRAME);
    check_lit("p1", 4, 4, 4, 4);
    check_val("p1_gap", gap_cnt, 8);
    check_val("p1_dp", dp_low, 0);

    // 2: two loads before boundary, last write wins
    run_to(7);
    clear_mon();
    watch_abcd = 1'b1;
    value = 16'hABCD; load = 1'b1; tick();
    load = 1'b0; run(2);
    value = 16'h5678; load = 1'b1; tick();
    load = 1'b0;
    run_to(0);
    run(FRAME);
    watch_abcd = 1'b0;
    check_val("p2_acks", ack_cnt, 1);
    check_val("p2_abcd_seen", abcd_seen, 0);

    // 3: load coincident with boundary, leading-zero blanking
    run_to(FRAME - 1);
    value = 16'h00F0; blank_lz = 1'b1; load = 1'b1;
    tick();
    load = 1'b0;
    check_val("p3_ack", load_ack, 1);
    clear_mon();
    run(FRAME);
    check_lit("p3_blank", 0, 0, 4, 4);
    blank_lz = 1'b0;
    clear_mon();
    run(FRAME);
    check_lit("p3_noblank", 4, 4, 4, 4);

    // 4: all-zero value with dp on a blanked digit, then digit 2 nonzero
    value = 16'h0000; dp_in = 4'b0100; blank_lz = 1'b1; load = 1'b1;
    tick();
    load = 1'b0;
    run_to(0);
    clear_mon();
    run(FRAME);
    check_lit("p4a", 0, 0, 0, 4);
    check_val("p4a_dp", dp_low, 0);
    value = 16'h0100; load = 1'b1;
    tick();
    load = 1'b0;
    run_to(0);
    clear_mon();
    run(FRAME);
    check_lit("p4b", 0, 4, 4, 4);
    check_val("p4b_dp", dp_low, 4);

    // 5: en dropped mid-ON of digit 1, load during the window
    clear_mon();
    run_to(9);
    en = 1'b0;
    tick();
    check_val("p5_an_off", an, 4'hF);
    check_val("p5_dp_off", dp, 1);
    value = 16'h9999; dp_in = 4'b0000; load = 1'b1;
    tick();
    load = 1'b0;
    run(8);
    check_val("p5_no_early_ack", ack_cnt, 0);
    en = 1'b1;
    run_to(0);
    check_lit("p5", 0, 4, 4, 4);
    check_val("p5_acks", ack_cnt, 1);

    // 6: reset mid-ON of digit 2 with a pending load
    run_to(15);
    value = 16'h1111; load = 1'b1;
    tick();
    load = 1'b0;
    rst_n = 1'b0;
    tick();
    check_val("p6_an", an, 4'hF);
    check_val("p6_x", x, 0);
    rst_n = 1'b1;
    clear_mon();
    run(30);
    check_val("p6_acks", ack_cnt, 0);
    check_val("p6_lit0", lit_cnt[0], 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan4.md
Name: seg7_scan4

Overview:
- Four-digit time-multiplexed scan controller for a common-anode 7-segment display.
- Sits directly upstream of the hex-to-segment decoder: it drives the decoder's 4-bit nibble input `x` and drives the digit anodes and decimal point itself.
- Holds a tear-free shadow copy of the displayed value. New values commit only at frame boundaries.
- Inserts an all-off gap between digits to suppress ghosting, and optionally blanks leading zeros.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit is lit (ON phase); legal range ≥1.
- GAP_CYC, 16, clock cycles with all anodes off before each digit lights (GAP phase); legal range ≥1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- en  input  1  scan enable; 0 blanks the display and freezes scanning.
- load  input  1  single-cycle strobe; captures value and dp_in.
- value  input  16  display value; nibble k drives digit k, with digit 0 the rightmost.
- dp_in  input  4  decimal point request per digit, 1 = lit.
- blank_lz  input  1  1 = blank leading zero digits.
- x  output  4  nibble to the segment decoder (registered).
- an  output  4  digit anodes, active-low (registered).
- dp  output  1  decimal point, active-low (registered).
- load_ack  output  1  one-cycle pulse when a loaded value commits to the shadow register.

Behaviour:

Reset (rst_n=0 at a clock edge):
- Outputs: an=4'b1111, dp=1, x=0, load_ack=0.
- Internal state: shadow value=0, shadow dp=0, pending=0, idx=0, state=GAP, cnt=0.

GAP state:
- Outputs: an=1111, dp=1, x=shadow nibble[idx].
- cnt counts 0..GAP_CYC-1.
- At GAP_CYC-1: cnt←0, state←ON.

ON state:
- an[idx]=0 unless blanked; all other an bits are 1.
- dp = ~shadow_dp[idx] when not blanked, else 1.
- cnt counts 0..REFRESH_DIV-1.
- At REFRESH_DIV-1: cnt←0, idx←idx+1 mod 4, state←GAP.
- Frame length is 4·(GAP_CYC+REFRESH_DIV) cycles.

Load handling:
- A frame boundary is the ON→GAP transition with idx=3, i.e. idx wrapping to 0.
- load=1 outside a boundary: pend_value←value, pend_dp←dp_in, pending←1. A later load before the boundary overwrites; last write wins.
- At a boundary with pending=1 and load=0: shadow←pend, pending←0, load_ack=1 for one cycle.
- load=1 coincident with a boundary: shadow←value/dp_in directly, pending←0, load_ack=1. Any older pending value is discarded.
- The shadow register never changes at any other time.

Leading-zero blanking:
- With blank_lz=1, digit k (k=3..1) is blanked when shadow nibbles 3..k are all 0. Digit 0 is never blanked.
- A blanked digit still consumes its GAP and ON slots, with an=1111 and dp=1.

en=0:
- an=1111 and dp=1 on the next edge; state, cnt and idx freeze.
- No frame boundary occurs, so pending is not committed. load is still captured into pending.
- When en returns to 1, scanning resumes from the frozen state and count.

Other rules:
- rst_n takes precedence over en and load. Reset mid-frame restarts from GAP, idx=0, and drops any pending value.
- All outputs are registered; no combinational path from any input to any output.

Test Plan (REFRESH_DIV=4, GAP_CYC=2; frame = 24 cycles):
1. Reset, then load value=16'h1234 with dp_in=0, en=1. Required:
   - load_ack pulses exactly once, at the first frame boundary.
   - Each subsequent frame shows an=1110/x=4, 1101/x=3, 1011/x=2, 0111/x=1, each lit exactly 4 cycles.
   - Every lit digit is preceded by exactly 2 cycles of an=1111.
   - dp stays 1 throughout.
2. Load 16'hABCD mid-frame, then 16'h5678 three cycles later, both before the boundary. Required:
   - The current frame still shows the old value.
   - At the boundary, load_ack pulses once and 16'h5678 is shown next; 16'hABCD is never displayed.
3. load=1 with value=16'h00F0, blank_lz=1, asserted exactly on the boundary cycle. Required:
   - Immediate commit and load_ack in that cycle.
   - Digit 3 slot shows an=1111.
   - Digit 2 slot also shows an=1111, since nibbles 3..2 are both 0.
   - Digits 1 and 0 light, showing x=F and x=0.
   - With blank_lz=0, all four digits light.
4. value=16'h0000, blank_lz=1, dp_in=4'b0100. Required:
   - Only digit 0 lights, x=0.
   - The digit 2 slot is blanked, so its dp is not shown.
   - Then set value=16'h0100: digit 2 lights with dp=0 while lit.
5. Drop en for 10 cycles mid-ON of digit 1. Required:
   - an=1111 and dp=1 from the next edge.
   - On restore, digit 1 finishes its remaining ON count; no digit is skipped.
   - A load issued during the en=0 window commits only at the next real boundary.
6. Assert rst_n=0 for one cycle mid-ON of digit 2, with a pending load outstanding. Required:
   - Next cycle: an=1111, x=0.
   - Scan restarts with 2 GAP cycles, then digit 0 displaying x=0.
   - load_ack never pulses for the dropped value.
